iter_cmp: RTL

//  Parametrised multi-cycle comparator; successor to the single-cycle branch CMP.

---
 rtl/iter_cmp_if.sv | 38 +++
 rtl/iter_cmp.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/iter_cmp_if.sv
// Request/result bundle for iter_cmp; the is_unsigned wire exists only when CMP_UNSIGNED_EN is defined.
interface iter_cmp_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       cond;
`ifdef CMP_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             ready;
    logic             done;
    logic             equal;
    logic             greater;
    logic             less;
    logic             taken;

`ifdef CMP_UNSIGNED_EN
    modport master (
        output start, data1, data2, cond, is_unsigned,
        input  ready, done, equal, greater, less, taken
    );
    modport slave (
        input  start, data1, data2, cond, is_unsigned,
        output ready, done, equal, greater, less, taken
    );
`else
    modport master (
        output start, data1, data2, cond,
        input  ready, done, equal, greater, less, taken
    );
    modport slave (
        input  start, data1, data2, cond,
        output ready, done, equal, greater, less, taken
    );
`endif
endinterface

// File: rtl/iter_cmp.sv
// Multi-cycle comparator: CHUNK bits per cycle, MSB chunk first, early exit on first difference.
// Optional CMP_UNSIGNED_EN adds a per-request unsigned mode; otherwise every compare is signed.
module iter_cmp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic      clk,
    input  logic      reset,
    iter_cmp_if.slave bus
);
    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]       state,   state_nxt;
    logic [CW-1:0]    cnt,     cnt_nxt;
    logic [WIDTH-1:0] a_q,     a_nxt;
    logic [WIDTH-1:0] b_q,     b_nxt;
    logic [2:0]       cond_q,  cond_nxt;
    logic             eq_q,    eq_nxt;
    logic             gt_q,    gt_nxt;
    logic             lt_q,    lt_nxt;
    logic             tk_q,    tk_nxt;
    logic             done_q,  done_nxt;
    logic             ready_q, ready_nxt;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [WIDTH-1:0] bias;
    logic             accept;
    logic             last;

    function automatic logic taken_of(input logic [2:0] c, input logic e, input logic g,
                                      input logic l);
        case (c)
            3'd0:    taken_of = e;
            3'd1:    taken_of = !e;
            3'd2:    taken_of = l;
            3'd3:    taken_of = !l;
            3'd4:    taken_of = l || e;
            3'd5:    taken_of = g;
            default: taken_of = 1'b0;
        endcase
    endfunction

    // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef CMP_UNSIGNED_EN
    assign bias = bus.is_unsigned ? '0 : MSB_BIT;
`else
    assign bias = MSB_BIT;
`endif

    assign accept  = bus.start && ready_q;
    assign last    = (cnt == CW'(N - 1));
    assign chunk_a = CHUNK'(a_q >> (CHUNK * (N - 1 - 32'(cnt))));
    assign chunk_b = CHUNK'(b_q >> (CHUNK * (N - 1 - 32'(cnt))));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a_q;
        b_nxt     = b_q;
        cond_nxt  = cond_q;
        eq_nxt    = eq_q;
        gt_nxt    = gt_q;
        lt_nxt    = lt_q;
        tk_nxt    = tk_q;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    a_nxt     = bus.data1 ^ bias;
                    b_nxt     = bus.data2 ^ bias;
                    cond_nxt  = bus.cond;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (chunk_a != chunk_b) begin
                    eq_nxt    = 1'b0;
                    gt_nxt    = chunk_a > chunk_b;
                    lt_nxt    = chunk_a < chunk_b;
                    tk_nxt    = taken_of(cond_q, 1'b0, chunk_a > chunk_b, chunk_a < chunk_b);
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else if (last) begin
                    eq_nxt    = 1'b1;
                    gt_nxt    = 1'b0;
                    lt_nxt    = 1'b0;
                    tk_nxt    = taken_of(cond_q, 1'b1, 1'b0, 1'b0);
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        ready_nxt = (state_nxt != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cond_q  <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            tk_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            cond_q  <= cond_nxt;
            eq_q    <= eq_nxt;
            gt_q    <= gt_nxt;
            lt_q    <= lt_nxt;
            tk_q    <= tk_nxt;
            done_q  <= done_nxt;
            ready_q <= ready_nxt;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.equal   = eq_q;
    assign bus.greater = gt_q;
    assign bus.less    = lt_q;
    assign bus.taken   = tk_q;
endmodule
